mips_fetch_queue: RTL and testbench



---
 rtl/mips_fetch_queue_if.sv | 32 +++
 rtl/mips_fetch_queue.sv | 132 +++++++++++++
 tb/tb_mips_fetch_queue.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response, redirect, and decode handshake.
// Latency: none (wires only).
// Backpressure: out_ready from decode stalls the head entry.
// master: driven by the fetch queue; slave: the memory/decode/branch side.
// Ports: imem_req/imem_addr/imem_rdata, redirect_valid/redirect_pc,
//        out_valid/out_ready/out_pc/out_instr, misalign_err.
interface mips_fetch_queue_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32,
    parameter int IMEM_AW  = 8
);
    logic                imem_req;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [XLEN-1:0]     imem_rdata;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [XLEN-1:0]     out_instr;
    logic                misalign_err;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr, misalign_err,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, misalign_err,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/mips_fetch_queue.sv
// Instruction fetch stage: pipelined imem requests feeding a QUEUE_DEPTH-entry prefetch FIFO.
// Latency: request in cycle c, head valid in c+2; redirect target valid 3 cycles after redirect.
// Backpressure: out_ready=0 holds the head; requests stop once queued + in-flight fills the FIFO.
// Ports: clock, reset_n (sync, active-low), fq (master modport of mips_fetch_queue_if).
module mips_fetch_queue #(
    parameter int                  XLEN        = 32,
    parameter int                  PC_WIDTH    = 32,
    parameter int                  IMEM_AW     = 8,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    mips_fetch_queue_if.master fq
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [PC_WIDTH-1:0] fpc_q, fpc_d;
    logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                resp_v_q, resp_v_d;
    logic                squash_q, squash_d;
    logic                misalign_q, misalign_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;

    logic [PC_WIDTH-1:0] pc_mem_q  [QUEUE_DEPTH];
    logic [XLEN-1:0]     ins_mem_q [QUEUE_DEPTH];

    logic credit_ok;
    logic req;
    logic out_valid;
    logic push;
    logic pop;

    // Credit counts the in-flight response but not a same-cycle pop, so a
    // response always finds a free slot when it lands.
    always_comb begin
        credit_ok = ({1'b0, cnt_q} + {{CW{1'b0}}, resp_v_q}) < (CW+1)'(QUEUE_DEPTH);
        req       = reset_n && !fq.redirect_valid && credit_ok;
        out_valid = reset_n && (cnt_q != '0);
        // Redirect wins over both a pop and an arriving response.
        pop       = out_valid && fq.out_ready && !fq.redirect_valid;
        push      = resp_v_q && !squash_q && !fq.redirect_valid;
    end

    always_comb begin
        fpc_d      = fpc_q;
        resp_pc_d  = resp_pc_q;
        resp_v_d   = req;
        squash_d   = fq.redirect_valid;
        misalign_d = misalign_q | (fq.redirect_valid && (fq.redirect_pc[1:0] != 2'b00));
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (req) begin
            resp_pc_d = fpc_q;
        end

        if (fq.redirect_valid) begin
            fpc_d    = {fq.redirect_pc[PC_WIDTH-1:2], 2'b00};
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (req) begin
                fpc_d = fpc_q + PC_WIDTH'(4);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fpc_q      <= RESET_PC;
            resp_pc_q  <= '0;
            resp_v_q   <= 1'b0;
            squash_q   <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fpc_q      <= fpc_d;
            resp_pc_q  <= resp_pc_d;
            resp_v_q   <= resp_v_d;
            squash_q   <= squash_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= resp_pc_q;
            ins_mem_q[wr_ptr_q] <= fq.imem_rdata;
        end
    end

    // Narrow PCs cannot cover the whole imem; zero-extend the word index then.
    generate
        if (PC_WIDTH >= IMEM_AW + 2) begin : g_addr_slice
            assign fq.imem_addr = fpc_q[IMEM_AW+1:2];
        end else begin : g_addr_ext
            assign fq.imem_addr = IMEM_AW'(fpc_q[PC_WIDTH-1:2]);
        end
    endgenerate

    assign fq.imem_req     = req;
    assign fq.out_valid    = out_valid;
    assign fq.out_pc       = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign fq.out_instr    = out_valid ? ins_mem_q[rd_ptr_q] : '0;
    assign fq.misalign_err = misalign_q;

    no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        (push && !pop) |-> (cnt_q != CW'(QUEUE_DEPTH)));
endmodule

// File: tb/tb_mips_fetch_queue.sv
module tb_mips_fetch_queue;
    logic clock;
    logic rst_n;
    logic rst2_n;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mips_fetch_queue_if #(.XLEN(32), .PC_WIDTH(32), .IMEM_AW(8)) f();
    mips_fetch_queue_if #(.XLEN(32), .PC_WIDTH(8),  .IMEM_AW(6)) g();

    mips_fetch_queue #(.XLEN(32), .PC_WIDTH(32), .IMEM_AW(8), .QUEUE_DEPTH(4), .RESET_PC(32'h0))
        dut (.clock(clock), .reset_n(rst_n), .fq(f));

    mips_fetch_queue #(.XLEN(32), .PC_WIDTH(8), .IMEM_AW(6), .QUEUE_DEPTH(4), .RESET_PC(8'h0))
        dut_w (.clock(clock), .reset_n(rst2_n), .fq(g));

    // Synchronous imem models: word i holds value i; garbage when not requested.
    always @(posedge clock) f.imem_rdata <= f.imem_req ? 32'(f.imem_addr) : 32'hDEADBEEF;
    always @(posedge clock) g.imem_rdata <= g.imem_req ? 32'(g.imem_addr) : 32'hDEADBEEF;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    logic [31:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_load(input logic [31:0] start, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every accepted head must be the next expected pc in order.
    always @(negedge clock) begin
        if (f.out_valid && f.out_ready && !f.redirect_valid) begin
            n_acc++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got pc %0h required no output", f.out_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check("sb_pc", 64'(f.out_pc), 64'(e));
                check("sb_instr", 64'(f.out_instr), 64'((e >> 2) & 32'hFF));
            end
        end
    end

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        exp_req;
        logic [7:0]  exp_addr;
        logic        exp_vld;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // reset row, then free-run cycles 0..5
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 32'h0, 32'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 32'h0, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 32'h0, 32'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 32'h0, 32'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 32'h4, 32'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'd4, 1'b1, 32'h8, 32'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 32'hC, 32'd3};

        rst_n = 1'b0; rst2_n = 1'b0;
        f.out_ready = 1'b0; f.redirect_valid = 1'b0; f.redirect_pc = '0;
        g.out_ready = 1'b1; g.redirect_valid = 1'b0; g.redirect_pc = '0;
        repeat (2) next();

        // Free run after reset: table of per-cycle expectations
        sb_load(32'h0, 64);
        for (int i = 0; i < 7; i++) begin
            rst_n = tbl[i].rst_n;
            f.out_ready = tbl[i].rdy;
            at_neg();
            check($sformatf("tbl%0d_req", i), 64'(f.imem_req), 64'(tbl[i].exp_req));
            check($sformatf("tbl%0d_addr", i), 64'(f.imem_addr), 64'(tbl[i].exp_addr));
            check($sformatf("tbl%0d_vld", i), 64'(f.out_valid), 64'(tbl[i].exp_vld));
            check($sformatf("tbl%0d_pc", i), 64'(f.out_pc), 64'(tbl[i].exp_pc));
            check($sformatf("tbl%0d_ins", i), 64'(f.out_instr), 64'(tbl[i].exp_ins));
            if (i == 0) check("rst_err", 64'(f.misalign_err), 64'(0));
            next();
        end

        // Backpressure: fill, then drain in order at full rate
        rst_n = 1'b0; f.out_ready = 1'b0; sb_load(32'h0, 64);
        next();
        rst_n = 1'b1;
        repeat (8) next();
        at_neg();
        check("bp_req_stopped", 64'(f.imem_req), 64'(0));
        check("bp_vld", 64'(f.out_valid), 64'(1));
        check("bp_head", 64'(f.out_pc), 64'(0));
        next();
        f.out_ready = 1'b1; n_acc = 0;
        repeat (10) next();
        check("bp_drain_rate", 64'(n_acc), 64'(10));

        // Flush with 3 queued + 1 in flight
        rst_n = 1'b0; f.out_ready = 1'b0; sb_load(32'h0, 0);
        next();
        rst_n = 1'b1;
        repeat (4) next();
        f.redirect_valid = 1'b1; f.redirect_pc = 32'h3C; sb_load(32'h3C, 64);
        at_neg();
        check("fl_t_vld", 64'(f.out_valid), 64'(1));
        check("fl_t_req", 64'(f.imem_req), 64'(0));
        next();
        f.redirect_valid = 1'b0; f.out_ready = 1'b1;
        at_neg();
        check("fl_t1_vld", 64'(f.out_valid), 64'(0));
        check("fl_t1_req", 64'(f.imem_req), 64'(1));
        check("fl_t1_addr", 64'(f.imem_addr), 64'(15));
        next();
        at_neg();
        check("fl_t2_vld", 64'(f.out_valid), 64'(0));
        check("fl_t2_ins", 64'(f.out_instr), 64'(0));
        next();
        at_neg();
        check("fl_t3_vld", 64'(f.out_valid), 64'(1));
        check("fl_t3_pc", 64'(f.out_pc), 64'(32'h3C));
        check("fl_t3_ins", 64'(f.out_instr), 64'(15));
        repeat (6) next();

        // Misaligned redirect while streaming
        f.redirect_valid = 1'b1; f.redirect_pc = 32'h41; sb_load(32'h40, 64);
        at_neg();
        check("mis_t_err", 64'(f.misalign_err), 64'(0));
        check("mis_t_req", 64'(f.imem_req), 64'(0));
        next();
        f.redirect_valid = 1'b0;
        at_neg();
        check("mis_t1_err", 64'(f.misalign_err), 64'(1));
        check("mis_t1_addr", 64'(f.imem_addr), 64'(16));
        next();
        repeat (5) next();
        at_neg();
        check("mis_held", 64'(f.misalign_err), 64'(1));
        next();

        // Back-to-back redirects: the last one wins
        f.redirect_valid = 1'b1; f.redirect_pc = 32'h100; sb_load(32'h100, 64);
        next();
        f.redirect_pc = 32'h200; sb_load(32'h200, 64);
        next();
        f.redirect_valid = 1'b0;
        next();
        next();
        at_neg();
        check("b2b_vld", 64'(f.out_valid), 64'(1));
        check("b2b_pc", 64'(f.out_pc), 64'(32'h200));
        check("b2b_ins", 64'(f.out_instr), 64'(128));
        repeat (4) next();

        // Reset mid-run with a full queue
        f.out_ready = 1'b0;
        repeat (8) next();
        at_neg();
        check("mr_full_vld", 64'(f.out_valid), 64'(1));
        next();
        rst_n = 1'b0; sb_load(32'h0, 64);
        at_neg();
        check("mr_rst_req", 64'(f.imem_req), 64'(0));
        check("mr_rst_vld", 64'(f.out_valid), 64'(0));
        check("mr_rst_err", 64'(f.misalign_err), 64'(1));
        next();
        rst_n = 1'b1; f.out_ready = 1'b1;
        at_neg();
        check("mr_r0_vld", 64'(f.out_valid), 64'(0));
        check("mr_r0_ins", 64'(f.out_instr), 64'(0));
        check("mr_r0_req", 64'(f.imem_req), 64'(1));
        check("mr_r0_addr", 64'(f.imem_addr), 64'(0));
        check("mr_r0_err", 64'(f.misalign_err), 64'(0));
        next();
        at_neg();
        check("mr_r1_vld", 64'(f.out_valid), 64'(0));
        next();
        at_neg();
        check("mr_r2_vld", 64'(f.out_valid), 64'(1));
        check("mr_r2_pc", 64'(f.out_pc), 64'(0));
        repeat (4) next();

        // Wrap: 8-bit PC, 6-bit word address
        rst2_n = 1'b1;
        next();
        next();
        g.redirect_valid = 1'b1; g.redirect_pc = 8'hF8;
        at_neg();
        check("wr_t_req", 64'(g.imem_req), 64'(0));
        next();
        g.redirect_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            at_neg();
            check($sformatf("wr_addr%0d", k), 64'(g.imem_addr), 64'((62 + k - 1) % 64));
            if (k >= 3) begin
                check($sformatf("wr_pc%0d", k), 64'(g.out_pc), 64'((248 + 4 * (k - 3)) % 256));
                check($sformatf("wr_ins%0d", k), 64'(g.out_instr), 64'((62 + k - 3) % 64));
            end
            next();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
